// File: rtl/serial_bit_tx_if.sv
// Valid/ready word handshake between a requester and serial_bit_tx.
// The requester is the master; the transmitter is the slave.
interface serial_bit_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: start(0), data LSB-first, [even parity], stop(1).
// Defining SERIAL_TX_PARITY_EN inserts the parity bit between data and stop.
module serial_bit_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    serial_bit_tx_if.slave    bus,
    output logic              tx_bit,
    output logic              busy
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IMAX = IW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_d;
    logic [TW-1:0]     timer, timer_d;
    logic [IW-1:0]     idx, idx_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic              tx_bit_d;
    logic              timer_last;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q;

    // Parity is taken from the word as captured; the shift register is consumed later.
    always_ff @(posedge clk) begin
        if (reset)
            par_q <= 1'b0;
        else if (state == IDLE && bus.tx_valid)
            par_q <= ^bus.tx_data;
    end
`endif

    assign bus.tx_ready = (state == IDLE);
    assign busy         = ~bus.tx_ready;
    assign timer_last   = (timer == TMAX);

    always_comb begin
        state_d = state;
        timer_d = timer;
        idx_d   = idx;
        shreg_d = shreg;
        if (state != IDLE)
            timer_d = timer_last ? '0 : timer + 1'b1;
        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d = START;
                    shreg_d = bus.tx_data;
                    timer_d = '0;
                    idx_d   = '0;
                end
            end
            START: if (timer_last) state_d = DATA;
            DATA: begin
                if (timer_last) begin
                    shreg_d = shreg >> 1;
                    if (idx == IMAX) begin
                        idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (timer_last) state_d = STOP;
`endif
            STOP: if (timer_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The line value is derived from the next state so tx_bit stays a pure flop output.
    always_comb begin
        tx_bit_d = 1'b1;
        case (state_d)
            START:   tx_bit_d = 1'b0;
            DATA:    tx_bit_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_bit_d = par_q;
`endif
            default: tx_bit_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            idx    <= '0;
            shreg  <= '0;
            tx_bit <= 1'b1;
        end else begin
            state  <= state_d;
            timer  <= timer_d;
            idx    <= idx_d;
            shreg  <= shreg_d;
            tx_bit <= tx_bit_d;
        end
    end
endmodule
